// File: rtl/mc_control_pkg.sv
// Shared encodings for the multicycle MIPS-subset control path: opcodes, funct
// codes, ALU operation codes, mux selects and the control FSM state encoding.
package mc_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_e;

  // Moore part of the control word; everything here depends on state alone.
  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
  } ctrl_t;

  // States that stall on mem_ready and are guarded by the wait counter.
  function automatic logic is_wait_state(state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mc_control_alu_decoder.sv
// Combinational R-type funct decoder: ALU operation plus a legality flag used
// by the control FSM to reject unsupported funct codes.
module alu_decoder
  import mc_control_pkg::*;
(
  input  logic [5:0] funct,
  output alu_op_e    alu_op,
  output logic       funct_ok
);

  // NOTE: every signal written in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alu_op   = ALU_ADD;
    funct_ok = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS-subset control unit: Moore FSM with a bounded wait on
// mem_ready in FETCH/MEMRD/MEMWR and one-cycle illegal/timeout pulses.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alu_op,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [3:0] state_o,
  output logic       illegal,
  output logic       mem_timeout
);

  localparam int CW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CW-1:0] WAIT_MAX = CW'(WAIT_LIMIT);

  state_e        state, state_n;
  logic [CW-1:0] wait_cnt, wait_cnt_n;
  alu_op_e       funct_op;
  logic          funct_ok;
  logic          op_illegal;
  logic          waiting;
  logic          timeout;
  ctrl_t         ctrl;

  alu_decoder u_alu_decoder (
    .funct    (funct),
    .alu_op   (funct_op),
    .funct_ok (funct_ok)
  );

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
    end
  end

  // The abort fires only once the counter already sits at the limit and memory
  // is still not ready; a ready on that same cycle completes normally.
  always_comb begin
    waiting = is_wait_state(state) && !mem_ready;
    timeout = waiting && (wait_cnt == WAIT_MAX);
  end

  always_comb begin
    op_illegal = 1'b0;
    case (opcode)
      OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: op_illegal = 1'b0;
      OP_RTYPE:                            op_illegal = !funct_ok;
      default:                             op_illegal = 1'b1;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_n = state;
    case (state)
      S_FETCH: begin
        if (timeout)        state_n = S_FETCH;
        else if (mem_ready) state_n = S_DECODE;
      end
      S_DECODE: begin
        if (op_illegal) begin
          state_n = S_FETCH;
        end else begin
          case (opcode)
            OP_LW, OP_SW: state_n = S_MEMADR;
            OP_RTYPE:     state_n = S_EXECUTE;
            OP_BEQ:       state_n = S_BRANCH;
            OP_ADDI:      state_n = S_ADDIEXEC;
            OP_J:         state_n = S_JUMP;
            default:      state_n = S_FETCH;
          endcase
        end
      end
      S_MEMADR:   state_n = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD: begin
        if (timeout)        state_n = S_FETCH;
        else if (mem_ready) state_n = S_MEMWB;
      end
      S_MEMWR: begin
        if (timeout || mem_ready) state_n = S_FETCH;
      end
      S_EXECUTE:  state_n = S_ALUWB;
      S_ADDIEXEC: state_n = S_ADDIWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: state_n = S_FETCH;
      default:    state_n = S_FETCH;
    endcase
  end

  // Any state change is an entry into a new state, which restarts the count.
  always_comb begin
    if (timeout || (state_n != state)) wait_cnt_n = '0;
    else if (waiting)                  wait_cnt_n = wait_cnt + 1'b1;
    else                               wait_cnt_n = wait_cnt;
  end

  // Output logic: Moore control word plus the few input-qualified strobes.
  always_comb begin
    ctrl     = '0;
    ir_write = 1'b0;
    pc_en    = 1'b0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_src    = PCSRC_ALU;
        ir_write       = reset_n && mem_ready && !timeout;
        pc_en          = reset_n && mem_ready && !timeout;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = funct_op;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_SUB;
        ctrl.pc_src    = PCSRC_ALUOUT;
        pc_en          = reset_n && zero;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_src = PCSRC_JUMP;
        pc_en       = reset_n;
      end
      default: ctrl = '0;
    endcase
  end

  assign alu_op      = ctrl.alu_op;
  assign alu_src_a   = ctrl.alu_src_a;
  assign alu_src_b   = ctrl.alu_src_b;
  assign pc_src      = ctrl.pc_src;
  assign mem_read    = ctrl.mem_read;
  assign mem_write   = ctrl.mem_write;
  assign iord        = ctrl.iord;
  assign reg_write   = ctrl.reg_write;
  assign reg_dst     = ctrl.reg_dst;
  assign mem_to_reg  = ctrl.mem_to_reg;
  assign state_o     = state;
  assign illegal     = reset_n && (state == S_DECODE) && op_illegal;
  assign mem_timeout = reset_n && timeout;

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: each scenario compares the full output
// vector cycle by cycle against hand-computed expectations.
module tb_mc_control;

  // Vector layout: {state_o, alu_op, alu_src_a, alu_src_b, pc_src,
  //   pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, illegal, mem_timeout}
  localparam logic [3:0] ST_EXEC = 4'd6;
  localparam logic [21:0] E_FETCH_RDY  = {4'd0,  3'b010, 1'b0, 2'b01, 2'b00, 10'b1110000000};
  localparam logic [21:0] E_FETCH_WAIT = {4'd0,  3'b010, 1'b0, 2'b01, 2'b00, 10'b0010000000};
  localparam logic [21:0] E_FETCH_TO   = {4'd0,  3'b010, 1'b0, 2'b01, 2'b00, 10'b0010000001};
  localparam logic [21:0] E_DECODE     = {4'd1,  3'b010, 1'b0, 2'b11, 2'b00, 10'b0000000000};
  localparam logic [21:0] E_DECODE_ILL = {4'd1,  3'b010, 1'b0, 2'b11, 2'b00, 10'b0000000010};
  localparam logic [21:0] E_MEMADR     = {4'd2,  3'b010, 1'b1, 2'b10, 2'b00, 10'b0000000000};
  localparam logic [21:0] E_MEMRD      = {4'd3,  3'b000, 1'b0, 2'b00, 2'b00, 10'b0010100000};
  localparam logic [21:0] E_MEMWB      = {4'd4,  3'b000, 1'b0, 2'b00, 2'b00, 10'b0000010100};
  localparam logic [21:0] E_MEMWR      = {4'd5,  3'b000, 1'b0, 2'b00, 2'b00, 10'b0001100000};
  localparam logic [21:0] E_MEMWR_TO   = {4'd5,  3'b000, 1'b0, 2'b00, 2'b00, 10'b0001100001};
  localparam logic [21:0] E_EXEC_ADD   = {4'd6,  3'b010, 1'b1, 2'b00, 2'b00, 10'b0000000000};
  localparam logic [21:0] E_ALUWB      = {4'd7,  3'b000, 1'b0, 2'b00, 2'b00, 10'b0000011000};
  localparam logic [21:0] E_BR_TAKEN   = {4'd8,  3'b110, 1'b1, 2'b00, 2'b01, 10'b1000000000};
  localparam logic [21:0] E_BR_NOT     = {4'd8,  3'b110, 1'b1, 2'b00, 2'b01, 10'b0000000000};
  localparam logic [21:0] E_ADDIEXEC   = {4'd9,  3'b010, 1'b1, 2'b10, 2'b00, 10'b0000000000};
  localparam logic [21:0] E_ADDIWB     = {4'd10, 3'b000, 1'b0, 2'b00, 2'b00, 10'b0000010000};
  localparam logic [21:0] E_JUMP       = {4'd11, 3'b000, 1'b0, 2'b00, 2'b10, 10'b1000000000};

  logic       clk = 1'b0;
  logic       reset_n;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic       pc_en, ir_write, mem_read, mem_write, iord;
  logic       reg_write, reg_dst, mem_to_reg;
  logic [3:0] state_o;
  logic       illegal, mem_timeout;

  int n_checks = 0;
  int n_pass   = 0;

  mc_control #(.WAIT_LIMIT(15)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .alu_op      (alu_op),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .pc_en       (pc_en),
    .ir_write    (ir_write),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .iord        (iord),
    .reg_write   (reg_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .state_o     (state_o),
    .illegal     (illegal),
    .mem_timeout (mem_timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [21:0] obs();
    return {state_o, alu_op, alu_src_a, alu_src_b, pc_src,
            pc_en, ir_write, mem_read, mem_write, iord,
            reg_write, reg_dst, mem_to_reg, illegal, mem_timeout};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    opcode    = 6'b000000;
    funct     = 6'b000000;
    zero      = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (obs() !== E_FETCH_WAIT) $display("FAIL reset_hold cyc%0d: got %b want %b", i, obs(), E_FETCH_WAIT);
      else n_pass++;
    end
    reset_n   = 1'b1;
    mem_ready = 1'b0;
    #1;
    n_checks++;
    if (obs() !== E_FETCH_WAIT) $display("FAIL reset_release: got %b want %b", obs(), E_FETCH_WAIT);
    else n_pass++;
    tick();
  endtask

  task automatic test_rtype();
    logic [5:0]  fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0]  op [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    logic [21:0] ev [4];
    opcode    = 6'b000000;
    mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      funct = fn[k];
      ev = '{E_FETCH_RDY, E_DECODE, {ST_EXEC, op[k], 1'b1, 2'b00, 2'b00, 10'b0}, E_ALUWB};
      for (int i = 0; i < 4; i++) begin
        #1;
        n_checks++;
        if (obs() !== ev[i]) $display("FAIL rtype_%b cyc%0d: got %b want %b", fn[k], i, obs(), ev[i]);
        else n_pass++;
        tick();
      end
    end
  endtask

  task automatic test_beq();
    logic [21:0] ev [3];
    opcode    = 6'b000100;
    mem_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      zero = (k == 0);
      ev = '{E_FETCH_RDY, E_DECODE, (k == 0) ? E_BR_TAKEN : E_BR_NOT};
      for (int i = 0; i < 3; i++) begin
        #1;
        n_checks++;
        if (obs() !== ev[i]) $display("FAIL beq_zero%0d cyc%0d: got %b want %b", zero, i, obs(), ev[i]);
        else n_pass++;
        tick();
      end
    end
    zero = 1'b0;
  endtask

  task automatic test_lw_wait();
    logic [21:0] ev [8] = '{E_FETCH_RDY, E_DECODE, E_MEMADR, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMRD, E_MEMWB};
    logic        mr [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      mem_ready = mr[i];
      #1;
      n_checks++;
      if (obs() !== ev[i]) $display("FAIL lw_wait cyc%0d: got %b want %b", i, obs(), ev[i]);
      else n_pass++;
      tick();
    end
  endtask

  // First store times out after 15 waiting cycles; second completes on the
  // very cycle the counter sits at the limit.
  task automatic test_sw_timeout();
    logic [21:0] ev [$];
    logic        mr [$];
    opcode = 6'b101011;
    for (int pass = 0; pass < 2; pass++) begin
      ev.push_back(E_FETCH_RDY); mr.push_back(1'b1);
      ev.push_back(E_DECODE);    mr.push_back(1'b1);
      ev.push_back(E_MEMADR);    mr.push_back(1'b1);
      for (int j = 0; j < 15; j++) begin
        ev.push_back(E_MEMWR); mr.push_back(1'b0);
      end
      if (pass == 0) begin
        ev.push_back(E_MEMWR_TO);   mr.push_back(1'b0);
        ev.push_back(E_FETCH_WAIT); mr.push_back(1'b0);
      end else begin
        ev.push_back(E_MEMWR);      mr.push_back(1'b1);
      end
    end
    foreach (ev[i]) begin
      mem_ready = mr[i];
      #1;
      n_checks++;
      if (obs() !== ev[i]) $display("FAIL sw_timeout cyc%0d: got %b want %b", i, obs(), ev[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_fetch_timeout_jump();
    logic [21:0] ev [$];
    logic        mr [$];
    opcode = 6'b000010;
    for (int j = 0; j < 15; j++) begin
      ev.push_back(E_FETCH_WAIT); mr.push_back(1'b0);
    end
    ev.push_back(E_FETCH_TO);   mr.push_back(1'b0);
    ev.push_back(E_FETCH_WAIT); mr.push_back(1'b0);
    ev.push_back(E_FETCH_RDY);  mr.push_back(1'b1);
    ev.push_back(E_DECODE);     mr.push_back(1'b1);
    ev.push_back(E_JUMP);       mr.push_back(1'b0);
    foreach (ev[i]) begin
      mem_ready = mr[i];
      #1;
      n_checks++;
      if (obs() !== ev[i]) $display("FAIL fetch_to_jump cyc%0d: got %b want %b", i, obs(), ev[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_addi();
    logic [21:0] ev [4] = '{E_FETCH_RDY, E_DECODE, E_ADDIEXEC, E_ADDIWB};
    opcode    = 6'b001000;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (obs() !== ev[i]) $display("FAIL addi cyc%0d: got %b want %b", i, obs(), ev[i]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_illegal();
    logic [5:0]  ops [2] = '{6'b111111, 6'b000000};
    logic [21:0] ev  [2] = '{E_FETCH_RDY, E_DECODE_ILL};
    mem_ready = 1'b1;
    funct     = 6'b000000;
    for (int k = 0; k < 2; k++) begin
      opcode = ops[k];
      for (int i = 0; i < 2; i++) begin
        #1;
        n_checks++;
        if (obs() !== ev[i]) $display("FAIL illegal_op%b cyc%0d: got %b want %b", ops[k], i, obs(), ev[i]);
        else n_pass++;
        tick();
      end
    end
  endtask

  // Reset lands mid-EXECUTE; the instruction is abandoned and the next fetch
  // loads IR only once mem_ready is high.
  task automatic test_reset_mid();
    logic        rs [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        mr [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        tk [10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [21:0] ev [10] = '{E_FETCH_RDY, E_DECODE, E_EXEC_ADD, E_FETCH_WAIT, E_FETCH_WAIT,
                             E_FETCH_WAIT, E_FETCH_RDY, E_DECODE, E_EXEC_ADD, E_ALUWB};
    opcode = 6'b000000;
    funct  = 6'b100000;
    for (int i = 0; i < 10; i++) begin
      reset_n   = rs[i];
      mem_ready = mr[i];
      #1;
      n_checks++;
      if (obs() !== ev[i]) $display("FAIL reset_mid cyc%0d: got %b want %b", i, obs(), ev[i]);
      else n_pass++;
      if (tk[i]) tick();
      else #1;
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_beq();
    test_lw_wait();
    test_sw_timeout();
    test_fetch_timeout_jump();
    test_addi();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got no completion want finish within 50000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 Parameter WAIT_LIMIT, default 15: maximum cycles spent waiting for mem_ready in one memory state before abort.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  6  instruction bits [31:26] from the instruction register.
REQ-005 funct  input  6  instruction bits [5:0] from the instruction register.
REQ-006 zero  input  1  ALU zero flag.
REQ-007 mem_ready  input  1  memory completes the current access this cycle.
REQ-008 alu_op  output  3  ALU operation code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT.
REQ-009 alu_src_a  output  1  0 = PC, 1 = register A.
REQ-010 alu_src_b  output  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left 2.
REQ-011 pc_src  output  2  00 = ALU result, 01 = ALUOut register, 10 = jump target.
REQ-012 pc_en, ir_write, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg  output  1 each  datapath strobes and selects.
REQ-013 state_o  output  4  current state encoding, debug only.
REQ-014 illegal, mem_timeout  output  1 each  one-cycle error pulses.

Function
REQ-015 The FSM SHALL have states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEXEC, ADDIWB, JUMP; all outputs except pc_en, ir_write and the error pulses are Moore functions of state; unlisted strobes are 0.
REQ-016 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=010, pc_src=00; ir_write=pc_en=mem_ready; advance to DECODE only when mem_ready=1, else hold.
REQ-017 DECODE (1 cycle): alu_src_a=0, alu_src_b=11, alu_op=010; next state by opcode: 100011/101011 -> MEMADR, 000000 -> EXECUTE, 000100 -> BRANCH, 001000 -> ADDIEXEC, 000010 -> JUMP.
REQ-018 Unknown opcode, or opcode 000000 with funct not in {100000,100010,100100,100101,101010}, SHALL pulse illegal in DECODE and return to FETCH with no write strobe.
REQ-019 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=010; lw -> MEMRD, sw -> MEMWR.
REQ-020 MEMRD: mem_read=1, iord=1; on mem_ready -> MEMWB. MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1 -> FETCH.
REQ-021 MEMWR: mem_write=1, iord=1; on mem_ready -> FETCH; mem_write held high for every waiting cycle.
REQ-022 EXECUTE: alu_src_a=1, alu_src_b=00, alu_op from funct (add 010, sub 110, and 000, or 001, slt 111) -> ALUWB. ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0 -> FETCH.
REQ-023 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=110, pc_src=01, pc_en=zero (combinational from zero) -> FETCH.
REQ-024 ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_op=010 -> ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0 -> FETCH.
REQ-025 JUMP: pc_src=10, pc_en=1 -> FETCH.
REQ-026 Latency excluding memory waits: R-type/addi/lw 4/4/5 cycles, sw 4, beq/j 3.
REQ-027 A wait counter SHALL clear on entry to FETCH/MEMRD/MEMWR and increment each cycle mem_ready=0; when it reaches WAIT_LIMIT with mem_ready still 0, pulse mem_timeout and go to FETCH, suppressing ir_write, pc_en and reg_write for that access.
REQ-028 mem_ready=1 on the same cycle the counter reaches WAIT_LIMIT SHALL count as completion, no timeout.

Reset
REQ-029 reset_n=0 SHALL immediately force state FETCH, clear the wait counter and drive illegal=mem_timeout=0; all other outputs take FETCH values, with ir_write=pc_en=0 while reset_n=0.
REQ-030 Reset asserted mid-instruction SHALL abandon it; no strobe of the abandoned state appears after reset deasserts.

Structure
REQ-031 A shared package SHALL hold opcode, funct, ALU operation-code and state-encoding constants, also used by the ALU and datapath.
REQ-032 The funct-to-alu_op mapping SHALL be a combinational sub-module alu_decoder, instanced once.

Verification
REQ-033 Reset mid-EXECUTE -> state_o=FETCH, reg_write never asserted, first fetch after release has ir_write only with mem_ready=1.
REQ-034 add (opcode 000000, funct 100000), mem_ready always 1 -> states FETCH,DECODE,EXECUTE,ALUWB; alu_op 010 in EXECUTE, reg_write=1/reg_dst=1 in ALUWB.
REQ-035 beq with zero=1 then zero=0 -> pc_en=1 with pc_src=01 in first BRANCH, pc_en=0 in second.
REQ-036 lw with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with mem_to_reg=1.
REQ-037 sw with mem_ready never high, WAIT_LIMIT=15 -> mem_timeout pulse after 15 waiting cycles, return to FETCH, no reg_write.
REQ-038 opcode 111111, then R-type funct 000000 -> illegal pulse in DECODE each time, next state FETCH.
